// File: rtl/control_link_pkg.sv
// Shared constants and state type for the control-link bus bridge.
package control_link_pkg;

  localparam logic [15:0] ADDR_BOARD_ID   = 16'h0000;
  localparam logic [15:0] ADDR_SCRATCH    = 16'h0001;
  localparam logic [15:0] ADDR_STATUS     = 16'h0002;
  localparam logic [15:0] LOCAL_ADDR_MAX  = 16'h0002;
  localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCAL = 2'd1,
    BUS   = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/control_link_bus_bridge_local_regs.sv
// Local register file: BOARD_ID, scratch and status read mux plus write decode.
module control_link_local_regs
  import control_link_pkg::*;
#(
  parameter logic [31:0] BOARD_ID = 32'hC0DE0001
) (
  input  logic        byte_clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  input  logic        timeout_err,
  input  logic [15:0] tmo_cnt,
  output logic [31:0] rdata,
  output logic        status_clr
);

  logic [31:0] scratch;

  always_ff @(posedge byte_clk) begin
    if (reset) begin
      scratch <= '0;
    end else if (wr_en && addr == ADDR_SCRATCH) begin
      scratch <= wdata;
    end
  end

  // Status counters live in the top-level FSM; this only flags the clearing write.
  assign status_clr = wr_en && (addr == ADDR_STATUS);

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_BOARD_ID: rdata = BOARD_ID;
      ADDR_SCRATCH:  rdata = scratch;
      ADDR_STATUS:   rdata = {15'h0, timeout_err, tmo_cnt};
      default:       rdata = '0;
    endcase
  end

endmodule

// File: rtl/control_link_bus_bridge.sv
// Bridges decoded control-link requests to local registers or a single-master local bus.
module control_link_bus_bridge
  import control_link_pkg::*;
#(
  parameter logic [31:0] BOARD_ID       = 32'hC0DE0001,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        byte_clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        requestIsWrite,
  input  logic [15:0] address,
  input  logic [31:0] dataOut,
  output logic        ack,
  output logic [31:0] dataIn,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_timeout_err
);

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES);

  state_e      state, state_d;
  logic        strobe_q;
  logic        lat_we, lat_we_d;
  logic [15:0] lat_addr, lat_addr_d;
  logic [31:0] lat_wdata, lat_wdata_d;
  logic        abandoned, abandoned_d;
  logic [15:0] timer, timer_d;
  logic [15:0] tmo_cnt, tmo_cnt_d;
  logic        err_d, ack_d, bus_req_d, bus_we_d;
  logic [31:0] data_in_d, bus_wdata_d;
  logic [15:0] bus_addr_d;
  logic        rise, host_gone, done;
  logic [31:0] local_rdata;
  logic        status_clr;

  assign rise = strobe & ~strobe_q;

  control_link_local_regs #(.BOARD_ID(BOARD_ID)) u_local_regs (
    .byte_clk    (byte_clk),
    .reset       (reset),
    .wr_en       ((state == LOCAL) && lat_we),
    .addr        (lat_addr),
    .wdata       (lat_wdata),
    .timeout_err (bus_timeout_err),
    .tmo_cnt     (tmo_cnt),
    .rdata       (local_rdata),
    .status_clr  (status_clr)
  );

  always_comb begin
    state_d     = state;
    lat_we_d    = lat_we;
    lat_addr_d  = lat_addr;
    lat_wdata_d = lat_wdata;
    abandoned_d = abandoned;
    timer_d     = timer;
    tmo_cnt_d   = tmo_cnt;
    err_d       = bus_timeout_err;
    ack_d       = ack;
    data_in_d   = dataIn;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    host_gone   = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          lat_we_d    = requestIsWrite;
          lat_addr_d  = address;
          lat_wdata_d = dataOut;
          if (address <= LOCAL_ADDR_MAX) begin
            state_d = LOCAL;
          end else begin
            state_d     = BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = requestIsWrite;
            bus_addr_d  = address;
            bus_wdata_d = dataOut;
            timer_d     = TMO_LOAD;
            abandoned_d = 1'b0;
          end
        end
      end
      LOCAL: begin
        ack_d     = 1'b1;
        data_in_d = lat_we ? lat_wdata : local_rdata;
        state_d   = HOLD;
        if (status_clr) begin
          tmo_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      BUS: begin
        // A strobe drop anywhere in the bus cycle marks the request abandoned.
        host_gone   = abandoned | ~strobe;
        abandoned_d = host_gone;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          data_in_d = lat_we ? lat_wdata : bus_rdata;
          done      = 1'b1;
        end else if (timer <= 16'd1) begin
          bus_req_d = 1'b0;
          data_in_d = TIMEOUT_PATTERN;
          err_d     = 1'b1;
          tmo_cnt_d = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
          done      = 1'b1;
        end else begin
          timer_d = timer - 16'd1;
        end
        if (done) begin
          if (host_gone) begin
            state_d = IDLE;
          end else begin
            ack_d   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!strobe) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge byte_clk) begin
    if (reset) begin
      state           <= IDLE;
      strobe_q        <= 1'b1;
      lat_we          <= 1'b0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      abandoned       <= 1'b0;
      timer           <= '0;
      tmo_cnt         <= '0;
      bus_timeout_err <= 1'b0;
      ack             <= 1'b0;
      dataIn          <= '0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
    end else begin
      state           <= state_d;
      strobe_q        <= strobe;
      lat_we          <= lat_we_d;
      lat_addr        <= lat_addr_d;
      lat_wdata       <= lat_wdata_d;
      abandoned       <= abandoned_d;
      timer           <= timer_d;
      tmo_cnt         <= tmo_cnt_d;
      bus_timeout_err <= err_d;
      ack             <= ack_d;
      dataIn          <= data_in_d;
      bus_req         <= bus_req_d;
      bus_we          <= bus_we_d;
      bus_addr        <= bus_addr_d;
      bus_wdata       <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_control_link_bus_bridge.sv
// Randomized scoreboard bench for control_link_bus_bridge against a transaction-level model.
module tb_control_link_bus_bridge;

  localparam int          TMO      = 8;
  localparam logic [31:0] BID      = 32'hC0DE0001;
  localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

  logic        byte_clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b1;
  logic        requestIsWrite = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] dataOut = '0;
  logic        ack;
  logic [31:0] dataIn;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        bus_timeout_err;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_scratch = '0;
  logic        m_err = 1'b0;
  logic [15:0] m_tmo = '0;

  control_link_bus_bridge #(.BOARD_ID(BID), .TIMEOUT_CYCLES(TMO)) dut (
    .byte_clk        (byte_clk),
    .reset           (reset),
    .strobe          (strobe),
    .requestIsWrite  (requestIsWrite),
    .address         (address),
    .dataOut         (dataOut),
    .ack             (ack),
    .dataIn          (dataIn),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack),
    .bus_timeout_err (bus_timeout_err)
  );

  always #5 byte_clk = ~byte_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack rising edge must match the oldest outstanding expectation.
  initial begin
    logic ack_prev;
    ack_prev = 1'b0;
    forever begin
      @(negedge byte_clk);
      if (ack === 1'b1 && ack_prev !== 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ack: got ack=1 with dataIn %h, required no ack", dataIn);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (dataIn !== e) begin
            fails++;
            $display("FAIL ack_data: got %h expected %h", dataIn, e);
          end
        end
      end
      ack_prev = ack;
    end
  end

  // delay: cycle of bus_req on which bus_ack is pulsed (0 = never).
  task automatic run_txn(input logic we, input logic [15:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int delay, input bit abandon_in);
    bit is_local, tmo, abandon, reraise;
    logic [31:0] exp_d;
    int exp_req, exp_ack_k, req_cycles, ack_k;
    is_local  = (a <= 16'h0002);
    abandon   = abandon_in && !is_local;
    tmo       = !is_local && !(delay >= 1 && delay <= TMO);
    reraise   = abandon && (delay == 0 || delay >= 4);
    exp_req   = is_local ? 0 : (tmo ? TMO : delay);
    exp_ack_k = abandon ? 0 : (is_local ? 2 : exp_req + 1);
    if (is_local) begin
      if (we) exp_d = wd;
      else if (a == 16'h0000) exp_d = BID;
      else if (a == 16'h0001) exp_d = m_scratch;
      else exp_d = {15'h0, m_err, m_tmo};
      if (we && a == 16'h0001) m_scratch = wd;
      if (we && a == 16'h0002) begin m_err = 1'b0; m_tmo = '0; end
    end else begin
      exp_d = tmo ? TMO_DATA : (we ? wd : rd);
      if (tmo) begin
        m_err = 1'b1;
        if (m_tmo != 16'hFFFF) m_tmo = m_tmo + 16'd1;
      end
    end
    if (!abandon) exp_q.push_back(exp_d);

    @(negedge byte_clk);
    strobe = 1'b1; requestIsWrite = we; address = a; dataOut = wd;
    req_cycles = 0; ack_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge byte_clk);
      if (bus_req === 1'b1) req_cycles++;
      if (ack === 1'b1 && ack_k == 0) ack_k = k;
      if (k == 1 && !is_local) begin
        check("bus_addr", {16'h0, bus_addr}, {16'h0, a});
        check("bus_we", {31'h0, bus_we}, {31'h0, we});
        check("bus_wdata", bus_wdata, wd);
      end
      bus_ack   = (k == delay);
      bus_rdata = (k == delay) ? rd : $urandom;
      if (abandon && k == 1) strobe = 1'b0;
      if (reraise && k == 2) strobe = 1'b1;
    end
    bus_ack = 1'b0;
    check("bus_req_cycles", req_cycles, exp_req);
    check("ack_latency", ack_k, exp_ack_k);
    check("timeout_err", {31'h0, bus_timeout_err}, {31'h0, m_err});
    if (abandon) check("abandon_data", dataIn, exp_d);
    strobe = 1'b0;
    @(negedge byte_clk);
    check("ack_fall", {31'h0, ack}, 32'h0);
    check("data_retain", dataIn, exp_d);
    @(negedge byte_clk);
  endtask

  initial begin
    int seen;
    // Reset with strobe held high: nothing may start until strobe drops.
    repeat (3) @(negedge byte_clk);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dataIn", dataIn, 32'h0);
    check("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_bus_addr", {16'h0, bus_addr}, 32'h0);
    check("rst_err", {31'h0, bus_timeout_err}, 32'h0);
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge byte_clk);
      if (ack === 1'b1 || bus_req === 1'b1) seen++;
    end
    check("held_strobe_ignored", seen, 0);
    strobe = 1'b0;
    repeat (2) @(negedge byte_clk);

    run_txn(1'b0, 16'h0000, 32'h0, 32'h0, 0, 1'b0);
    run_txn(1'b1, 16'h0001, 32'h12345678, 32'h0, 0, 1'b0);
    run_txn(1'b0, 16'h0001, 32'h0, 32'h0, 0, 1'b0);
    run_txn(1'b1, 16'h0000, 32'h5555AAAA, 32'h0, 0, 1'b0);
    run_txn(1'b0, 16'h0000, 32'h0, 32'h0, 0, 1'b0);
    run_txn(1'b0, 16'h4000, 32'h0, 32'hA5A5A5A5, 3, 1'b0);
    run_txn(1'b0, 16'h4000, 32'h0, 32'h11111111, 0, 1'b0);
    run_txn(1'b0, 16'h0002, 32'h0, 32'h0, 0, 1'b0);
    run_txn(1'b1, 16'h0002, 32'h0, 32'h0, 0, 1'b0);
    run_txn(1'b0, 16'h0002, 32'h0, 32'h0, 0, 1'b0);
    run_txn(1'b0, 16'h8000, 32'h0, 32'h22222222, TMO, 1'b0);
    run_txn(1'b1, 16'h0003, 32'hCAFEF00D, 32'h33333333, 1, 1'b0);
    run_txn(1'b0, 16'h4000, 32'h0, 32'h44444444, 0, 1'b1);
    run_txn(1'b0, 16'h4000, 32'h0, 32'h66666666, 5, 1'b1);

    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      int sel;
      sel = $urandom_range(0, 5);
      a = (sel < 3) ? 16'(sel) : 16'($urandom_range(3, 16'hFFFF));
      run_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom,
              $urandom_range(0, 11), ($urandom_range(0, 4) == 0));
    end
    run_txn(1'b0, 16'h0002, 32'h0, 32'h0, 0, 1'b0);

    // Reset in the middle of a bus cycle.
    @(negedge byte_clk);
    strobe = 1'b1; requestIsWrite = 1'b0; address = 16'h1234;
    repeat (3) @(negedge byte_clk);
    check("midbus_req_high", {31'h0, bus_req}, 32'h1);
    reset = 1'b1;
    @(negedge byte_clk);
    check("midbus_rst_req", {31'h0, bus_req}, 32'h0);
    check("midbus_rst_ack", {31'h0, ack}, 32'h0);
    check("midbus_rst_addr", {16'h0, bus_addr}, 32'h0);
    check("midbus_rst_err", {31'h0, bus_timeout_err}, 32'h0);
    reset = 1'b0; strobe = 1'b0;
    m_scratch = '0; m_err = 1'b0; m_tmo = '0;
    repeat (2) @(negedge byte_clk);
    run_txn(1'b0, 16'h0001, 32'h0, 32'h0, 0, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
